// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fetch_unit_pkg;

  // Fetch sequencer states. HOLD means the skid buffer is full.
  // DRAIN means a wrong-path memory reply is still owed.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_t;

  // sll $0,$0,0: the encoding decode sees for a bubble.
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_unit_ifid_reg.sv
// IF/ID pipeline register: instruction, PC+4 and a valid flag.
// Latency: one cycle from inputs to outputs.
// Backpressure: en_i=0 holds the contents; clr_i loads a bubble (PC+4 is kept).
module ifid_reg
  import fetch_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en_i,
  input  logic            clr_i,
  input  logic [XLEN-1:0] instr_i,
  input  logic [XLEN-1:0] pcplus4_i,
  output logic [XLEN-1:0] instr_o,
  output logic [XLEN-1:0] pcplus4_o,
  output logic            valid_o
);

  logic [XLEN-1:0] instr_q;
  logic [XLEN-1:0] pcplus4_q;
  logic            valid_q;

  // Load a real instruction or a bubble whenever enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q   <= XLEN'(NOP_INSTR);
      pcplus4_q <= '0;
      valid_q   <= 1'b0;
    end else if (en_i) begin
      if (clr_i) begin
        instr_q <= XLEN'(NOP_INSTR);
        valid_q <= 1'b0;
      end else begin
        instr_q   <= instr_i;
        pcplus4_q <= pcplus4_i;
        valid_q   <= 1'b1;
      end
    end
  end

  assign instr_o   = instr_q;
  assign pcplus4_o = pcplus4_q;
  assign valid_o   = valid_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, variable-latency imem handshake, one-entry skid, IF/ID register.
// Latency: imem ack on cycle N -> instrD valid after edge N.
// Backpressure: stallF parks a returned instruction in the skid and drops imem_req; stallD holds IF/ID.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stallF,
  input  logic            stallD,
  input  logic            pcsrcD,
  input  logic [XLEN-1:0] pcbranchD,
  input  logic            jumpD,
  input  logic [XLEN-1:0] pcjumpD,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] instrD,
  output logic [XLEN-1:0] pcplus4D,
  output logic            validD
);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic            req_q, req_d;
  logic [XLEN-1:0] skid_instr_q, skid_instr_d;
  logic [XLEN-1:0] skid_pc4_q, skid_pc4_d;

  logic            redirect;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] pc_plus4;
  logic            avail;
  logic [XLEN-1:0] avail_instr;
  logic [XLEN-1:0] avail_pc4;

  // A decode-stage redirect only counts when decode itself is not stalled; branch beats jump.
  assign redirect = (pcsrcD | jumpD) & ~stallD;
  assign target   = pcsrcD ? pcbranchD : pcjumpD;
  assign pc_plus4 = pc_q + XLEN'(4);

  // Next-state, PC, skid and "instruction available" decisions.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    skid_instr_d = skid_instr_q;
    skid_pc4_d   = skid_pc4_q;
    avail        = 1'b0;
    avail_instr  = imem_rdata;
    avail_pc4    = pc_plus4;

    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (imem_ack) begin
          if (stallF) begin
            skid_instr_d = imem_rdata;
            skid_pc4_d   = pc_plus4;
            state_d      = HOLD;
          end else begin
            avail = 1'b1;
            pc_d  = pc_plus4;
          end
        end
      end
      HOLD: begin
        if (!stallF) begin
          avail       = 1'b1;
          avail_instr = skid_instr_q;
          avail_pc4   = skid_pc4_q;
          pc_d        = pc_plus4;
          state_d     = REQ;
        end
      end
      DRAIN: begin
        // The reply belongs to the abandoned path; drop it.
        if (imem_ack) state_d = REQ;
      end
      default: state_d = IDLE;
    endcase

    // A redirect overrides everything; a reply still owed forces a drain first.
    if (redirect) begin
      pc_d         = target;
      avail        = 1'b0;
      skid_instr_d = '0;
      skid_pc4_d   = '0;
      if ((state_q == REQ || state_q == DRAIN) && !imem_ack) begin
        state_d = DRAIN;
      end else begin
        state_d = REQ;
      end
    end
  end

  // Request is registered; the address only moves when a fresh request is issued,
  // so it stays stable for the whole outstanding transaction (including DRAIN).
  always_comb begin
    req_d  = (state_d == REQ) || (state_d == DRAIN);
    addr_d = (state_d == REQ) ? {pc_d[XLEN-1:2], 2'b00} : addr_q;
  end

  // Sequencer, PC, request and skid registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      addr_q       <= {RESET_PC[XLEN-1:2], 2'b00};
      req_q        <= 1'b0;
      skid_instr_q <= '0;
      skid_pc4_q   <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      addr_q       <= addr_d;
      req_q        <= req_d;
      skid_instr_q <= skid_instr_d;
      skid_pc4_q   <= skid_pc4_d;
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = addr_q;

  ifid_reg #(
    .XLEN(XLEN)
  ) u_ifid (
    .clk      (clk),
    .rst_n    (reset),
    .en_i     (~stallD | redirect),
    .clr_i    (redirect | ~avail),
    .instr_i  (avail_instr),
    .pcplus4_i(avail_pc4),
    .instr_o  (instrD),
    .pcplus4_o(pcplus4D),
    .valid_o  (validD)
  );

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline, directly upstream of decode.
- Owns the PC register, the variable-latency instruction-memory request handshake, a one-entry skid buffer and the IF/ID pipeline register.
- Consumes stallF/stallD from the hazard unit and branch/jump redirects resolved in decode.
- Delivers instrD/pcplus4D/validD to decode.

Parameters:
- RESET_PC, 32'h0000_0000, PC fetched first after reset.
- XLEN, 32, address/instruction width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- stallF  in  1  hazard stall for fetch: hold PC, do not consume returned instruction.
- stallD  in  1  hazard stall for decode: hold IF/ID register.
- pcsrcD  in  1  taken branch resolved in decode.
- pcbranchD  in  XLEN  branch target.
- jumpD  in  1  jump in decode.
- pcjumpD  in  XLEN  jump target.
- imem_req  out  1  fetch request valid.
- imem_addr  out  XLEN  fetch address, word aligned.
- imem_ack  in  1  one-cycle pulse: imem_rdata valid.
- imem_rdata  in  XLEN  returned instruction.
- instrD  out  XLEN  IF/ID instruction; 0 (sll nop) when invalid.
- pcplus4D  out  XLEN  IF/ID PC+4.
- validD  out  1  IF/ID holds a real instruction.

Behaviour:
- Reset (async, reset=0):
  - state=IDLE, pcF=RESET_PC, imem_req=0, skid empty.
  - instrD=0, pcplus4D=0, validD=0.
  - An outstanding memory transaction is abandoned; memory is reset by the same signal.
- States: IDLE, REQ, HOLD, DRAIN.
  - IDLE -> REQ on the first clk edge after reset release.
  - imem_req is registered, 1 in REQ and DRAIN; imem_addr=pcF.
  - Address and req stay stable until ack. imem_ack outside REQ/DRAIN is ignored.
- redirect = (pcsrcD | jumpD) & ~stallD. pcsrcD has priority over jumpD.
- REQ, no redirect:
  - ack & ~stallF: instruction available; pcF <= pcF+4; remain REQ. Next request is presented the following cycle (one-cycle throughput gap allowed).
  - ack & stallF: rdata and pcF+4 written to skid; go HOLD; imem_req drops.
  - no ack: stay REQ.
- HOLD, no redirect:
  - stallF=1: stay, skid retained.
  - stallF=0: skid is available; pcF <= pcF+4; go REQ.
- Redirect, any state: pcF <= target; skid cleared; IF/ID loads bubble.
  - Next state REQ if nothing is outstanding (HOLD, or REQ with ack this cycle; that ack's data is discarded).
  - Otherwise next state DRAIN.
- DRAIN: wait for ack, discard data, then go REQ at pcF. A second redirect in DRAIN updates pcF and remains DRAIN.
- IF/ID update rules, in priority order:
  - redirect -> bubble.
  - stallD=1 -> hold.
  - instruction available -> instrD/pcplus4D/validD=1.
  - otherwise -> bubble (validD=0, instrD=0, pcplus4D unchanged).
- Arithmetic:
  - PC+4 modulo 2^XLEN; 32'hFFFF_FFFC wraps to 0.
  - Targets are used as given; low two bits are forced to 0 on imem_addr.
- Latency: ack on cycle N -> instrD valid after edge N.

Decomposition:
- fetch_pkg: fetch_state_t enum (IDLE, REQ, HOLD, DRAIN), NOP_INSTR = 32'h0, default RESET_PC constant.
- Sub-module ifid_reg: XLEN-wide enable/clear register with validD; async active-low reset. Enable = ~stallD | redirect; clear = redirect | ~available.

Test Plan:
- Reset release, memory acks 1 cycle after req -> imem_addr 0,4,8 in sequence. instrD follows rdata 0x20080005, 0x20090003, 0x01095020. pcplus4D = 4, 8, 12.
- Ack at addr 0x10 while stallF=stallD=1 for 3 cycles -> imem_req low during stall, instrD unchanged. After release: instrD = skid data, next imem_addr=0x14.
- pcsrcD=1, pcbranchD=0x40, no outstanding request -> next validD=0, next imem_addr=0x40, no instruction from the old path reaches decode.
- jumpD=1, pcjumpD=0x100 while request to 0x20 is pending with 4-cycle latency -> DRAIN. Ack data for 0x20 discarded, then req to 0x100. validD stays 0 until 0x100 returns.
- pcsrcD=1 and jumpD=1 same cycle (targets 0x80/0x200) -> fetch 0x80. With stallD=1 the redirect is ignored.
- PC at 32'hFFFF_FFFC acked -> pcplus4D=0, next imem_addr=0. Reset pulled mid-DRAIN -> all outputs return to reset values immediately, next fetch at RESET_PC.
